cache_ctrl_dm: RTL and testbench
================================

CACHE_CTRL_DM -- requirements
Module: cache_ctrl_dm

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of 2, 1 byte per line).
REQ-002 Parameter TIMEOUT, default 64, maximum cycles spent waiting for bus_finish.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU request strobe, sampled only in IDLE.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  8  byte address.
REQ-008 cpu_wdata  input  8  write data.
REQ-009 cpu_rdata  output  8  read data, valid while cpu_ready is high.
REQ-010 cpu_ready  output  1  one-cycle completion pulse.
REQ-011 cpu_err  output  1  high with cpu_ready when a bus timeout occurred.
REQ-012 cpu_busy  output  1  high in every state except IDLE.
REQ-013 bus_start  output  1  one-cycle request pulse to the downstream memory bus stage.
REQ-014 bus_write_op  output  1  bus operation type, 1 = write.
REQ-015 bus_address  output  8  bus address.
REQ-016 bus_data  output  8  bus write data.
REQ-017 bus_rdata  input  8  bus read data, valid with bus_finish.
REQ-018 bus_finish  input  1  bus completion flag.
REQ-019 hit_count  output  8  saturating count of read and write hits.
REQ-020 miss_count  output  8  saturating count of read and write misses.

Function
REQ-021 Address split: index = cpu_addr[log2(LINES)-1:0]; tag = the remaining upper bits. Each line holds a valid bit, a tag and 8 data bits.
REQ-022 FSM states: IDLE, LOOKUP, RD_BUS, WR_BUS, RESP.
REQ-023 IDLE: when cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, and go to LOOKUP. cpu_req in any other state is ignored.
REQ-024 LOOKUP, read hit: cpu_rdata = line data, cpu_ready = 1 for one cycle, increment hit_count, return to IDLE. Read-hit latency is 1 cycle after the accept edge.
REQ-025 LOOKUP, read miss: increment miss_count; pulse bus_start for exactly one cycle with bus_write_op=0 and bus_address = the latched address; go to RD_BUS.
REQ-026 RD_BUS, on bus_finish=1: write bus_rdata into the line, set valid and tag, then go to RESP.
REQ-027 RESP: drive cpu_ready=1 for one cycle with cpu_rdata = the filled data, then return to IDLE.
REQ-028 LOOKUP, write (write-through, no-allocate): on a hit, update the line data and increment hit_count; on a miss, leave the line untouched and increment miss_count.
REQ-029 In both write cases, pulse bus_start with bus_write_op=1, bus_address = the latched address and bus_data = the latched data, then go to WR_BUS.
REQ-030 WR_BUS, on bus_finish=1: cpu_ready=1 for one cycle, return to IDLE.
REQ-031 bus_address, bus_data and bus_write_op stay stable from the bus_start cycle until bus_finish is sampled.
REQ-032 bus_start is never high for two consecutive cycles.
REQ-033 bus_finish outside RD_BUS or WR_BUS is ignored.
REQ-034 A wait counter runs in RD_BUS and WR_BUS.
REQ-035 If the wait counter reaches TIMEOUT without bus_finish, assert cpu_ready=1 and cpu_err=1 for one cycle and return to IDLE.
REQ-036 On a read timeout, the line is not modified.
REQ-037 hit_count and miss_count hold at 255 and do not wrap.
REQ-038 A back-to-back request (cpu_req high in the first IDLE cycle after cpu_ready) is accepted with no dead cycle.

Reset
REQ-039 While rst=0, asynchronously: state = IDLE, all valid bits = 0, wait counter = 0.
REQ-040 While rst=0, asynchronously, every output = 0: cpu_rdata, cpu_ready, cpu_err, cpu_busy, bus_start, bus_write_op, bus_address, bus_data, hit_count, miss_count.
REQ-041 Reset asserted mid-transaction abandons the transaction without producing cpu_ready; a subsequent bus_finish is ignored.

Verification
REQ-042 Read miss: after reset, read 0x35 with the bus returning 0xA7 after 5 cycles -> one bus_start (write_op=0, addr 0x35); cpu_ready with rdata 0xA7; miss_count=1.
REQ-043 Read hit: read 0x35 again -> no bus_start; cpu_ready 1 cycle after accept with rdata 0xA7; hit_count=1.
REQ-044 Conflict: read 0x45 (same index, tag 4) -> miss, bus read; a later read of 0x35 misses again.
REQ-045 Write: write 0x5C to 0x45 (hit) -> bus write with addr 0x45, data 0x5C; a later read of 0x45 hits with 0x5C. Write 0x11 to 0x99 (miss) -> bus write only; read 0x99 then misses.
REQ-046 Timeout: with bus_finish held 0, a read -> cpu_ready and cpu_err together exactly TIMEOUT cycles after bus_start; the line stays invalid.
REQ-047 Reset and saturation: rst low during RD_BUS -> no cpu_ready, counters 0, the next read misses; 300 hits -> hit_count=255.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// rtl/cache_ctrl_dm.sv - direct-mapped 1-byte-line cache controller, write-through no-allocate
module cache_ctrl_dm #(
  parameter int LINES   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       cpu_err,
  output logic       cpu_busy,
  output logic       bus_start,
  output logic       bus_write_op,
  output logic [7:0] bus_address,
  output logic [7:0] bus_data,
  input  logic [7:0] bus_rdata,
  input  logic       bus_finish,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 8 - IW;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, RD_BUS, WR_BUS, RESP} state_t;

  state_t            state;
  logic              req_we;
  logic [7:0]        req_addr;
  logic [7:0]        req_wdata;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_mem  [LINES];
  logic [7:0]        data_mem [LINES];
  logic [CW-1:0]     wait_cnt;

  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic              hit;
  logic              timed_out;
  logic              fill_we;
  logic              wr_hit_we;

  assign req_idx   = req_addr[IW-1:0];
  assign req_tag   = req_addr[7:IW];
  assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
  assign fill_we   = (state == RD_BUS) && bus_finish;
  assign wr_hit_we = (state == LOOKUP) && req_we && hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Tag/data storage carries no reset; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= bus_rdata;
    end else if (wr_hit_we) begin
      data_mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      req_we       <= 1'b0;
      req_addr     <= 8'h00;
      req_wdata    <= 8'h00;
      valid        <= '0;
      wait_cnt     <= '0;
      cpu_rdata    <= 8'h00;
      cpu_ready    <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_busy     <= 1'b0;
      bus_start    <= 1'b0;
      bus_write_op <= 1'b0;
      bus_address  <= 8'h00;
      bus_data     <= 8'h00;
      hit_count    <= 8'h00;
      miss_count   <= 8'h00;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      bus_start <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            cpu_busy  <= 1'b1;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          wait_cnt <= '0;
          if (!req_we && hit) begin
            cpu_rdata <= data_mem[req_idx];
            cpu_ready <= 1'b1;
            cpu_busy  <= 1'b0;
            hit_count <= sat_inc(hit_count);
            state     <= IDLE;
          end else begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
            bus_start    <= 1'b1;
            bus_write_op <= req_we;
            bus_address  <= req_addr;
            if (req_we) begin
              bus_data <= req_wdata;
              state    <= WR_BUS;
            end else begin
              state    <= RD_BUS;
            end
          end
        end
        RD_BUS, WR_BUS: begin
          if (bus_finish) begin
            wait_cnt <= '0;
            if (state == RD_BUS) begin
              valid[req_idx] <= 1'b1;
              state          <= RESP;
            end else begin
              cpu_ready <= 1'b1;
              cpu_busy  <= 1'b0;
              state     <= IDLE;
            end
          end else if (timed_out) begin
            wait_cnt  <= '0;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          // Fill data was written into the line on the bus_finish edge.
          cpu_rdata <= data_mem[req_idx];
          cpu_ready <= 1'b1;
          cpu_busy  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          cpu_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb/tb_cache_ctrl_dm.sv - randomized self-checking bench for cache_ctrl_dm against a line-array model
module tb_cache_ctrl_dm;

  localparam int LINES   = 16;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_ready, cpu_err, cpu_busy;
  logic       bus_start, bus_write_op;
  logic [7:0] bus_address, bus_data, bus_rdata;
  logic       bus_finish;
  logic [7:0] hit_count, miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_valid [LINES];
  int         m_tag   [LINES];
  logic [7:0] m_data  [LINES];
  int         m_hits, m_miss;

  always #5 clk = ~clk;

  cache_ctrl_dm #(.LINES(LINES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .bus_start(bus_start), .bus_write_op(bus_write_op), .bus_address(bus_address),
    .bus_data(bus_data), .bus_rdata(bus_rdata), .bus_finish(bus_finish),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic check_outputs_zero();
    check("rst_rdata", cpu_rdata, 0);
    check("rst_ready", cpu_ready, 0);
    check("rst_err", cpu_err, 0);
    check("rst_busy", cpu_busy, 0);
    check("rst_start", bus_start, 0);
    check("rst_wop", bus_write_op, 0);
    check("rst_baddr", bus_address, 0);
    check("rst_bdata", bus_data, 0);
    check("rst_hits", hit_count, 0);
    check("rst_miss", miss_count, 0);
  endtask

  // One CPU transaction; delay<0 means the bus never answers.
  task automatic txn(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                     input int delay, input logic [7:0] rd_val);
    int  idx   = addr % LINES;
    int  tg    = addr / LINES;
    bit  hit   = m_valid[idx] && (m_tag[idx] == tg);
    bit  use_bus = we || !hit;
    int  start_cyc = -1, fin_cyc = -1, starts = 0, ready_cyc = -1;
    bit  done = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int cyc = 1; cyc <= TIMEOUT + 20 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_lookup", cpu_busy, 1);
      if (bus_start) begin
        starts++;
        start_cyc = cyc;
        check("bus_wop", bus_write_op, we);
        check("bus_addr", bus_address, addr);
        if (we) check("bus_data", bus_data, wd);
      end else if (start_cyc > 0 && fin_cyc < 0) begin
        check("stable_addr", bus_address, addr);
        check("stable_wop", bus_write_op, we);
        if (we) check("stable_data", bus_data, wd);
      end
      if (cpu_ready) begin
        done = 1'b1;
        ready_cyc = cyc;
        check("busy_at_ready", cpu_busy, 0);
        check("err", cpu_err, (use_bus && delay < 0) ? 1 : 0);
        if (!we && !hit && delay >= 0) check("miss_rdata", cpu_rdata, rd_val);
        if (!we && hit) begin
          check("hit_rdata", cpu_rdata, m_data[idx]);
          check("hit_latency", ready_cyc, 2);
        end
        if (use_bus && delay < 0) check("timeout_lat", ready_cyc - start_cyc, TIMEOUT);
        if (use_bus && delay >= 0) check("ready_after_fin", fin_cyc > 0, 1);
      end
      cpu_req    = done ? 1'b0 : 1'($urandom_range(0, 1));
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_addr   = 8'($urandom);
      cpu_wdata  = 8'($urandom);
      bus_finish = 1'b0;
      bus_rdata  = 8'($urandom);
      if (!done) begin
        if (start_cyc > 0 && fin_cyc < 0 && delay >= 0 && cyc == start_cyc + delay) begin
          bus_finish = 1'b1;
          bus_rdata  = rd_val;
          fin_cyc    = cyc;
        end else if (cyc == 1 || (fin_cyc > 0 && cyc > fin_cyc)) begin
          bus_finish = 1'($urandom_range(0, 1));
        end
      end
    end
    cpu_req = 1'b0; bus_finish = 1'b0;
    check("ready_seen", done, 1);
    check("bus_starts", starts, use_bus ? 1 : 0);
    if (hit) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
    else     m_miss = (m_miss < 255) ? m_miss + 1 : 255;
    if (!we && !hit && delay >= 0) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = rd_val;
    end
    if (we && hit) m_data[idx] = wd;
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_miss);
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    bus_rdata = 8'h00; bus_finish = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero();
    rst = 1'b1;

    txn(0, 8'h35, 8'h00, 5, 8'hA7);
    txn(0, 8'h35, 8'h00, 5, 8'h00);
    txn(0, 8'h45, 8'h00, 3, 8'h3C);
    txn(1, 8'h45, 8'h5C, 2, 8'h00);
    txn(0, 8'h45, 8'h00, 2, 8'h00);
    check("wr_hit_data", m_data[5], 8'h5C);
    txn(0, 8'h35, 8'h00, 4, 8'hA7);
    txn(1, 8'h99, 8'h11, 1, 8'h00);
    txn(0, 8'h99, 8'h00, 1, 8'h42);
    txn(0, 8'h77, 8'h00, -1, 8'h00);
    txn(0, 8'h77, 8'h00, 2, 8'h6D);

    // Back-to-back read hits on 0x35.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h35;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check("b2b_ready1", cpu_ready, 1);
    check("b2b_rdata1", cpu_rdata, 8'hA7);
    cpu_req = 1'b1;
    @(negedge clk);
    check("b2b_busy", cpu_busy, 1);
    check("b2b_noready", cpu_ready, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("b2b_ready2", cpu_ready, 1);
    check("b2b_rdata2", cpu_rdata, 8'hA7);
    m_hits += 2;
    check("b2b_hits", hit_count, m_hits);

    // Reset during RD_BUS abandons the fill.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hE2;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_test_start", bus_start, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    bus_finish = 1'b1; bus_rdata = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_finish = 1'b0;
      check("rst_no_ready", cpu_ready, 0);
    end
    txn(0, 8'h35, 8'h00, 3, 8'h19);
    txn(0, 8'hE2, 8'h00, 2, 8'h21);

    // Randomized traffic over a few indices and tags.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a = 8'($urandom_range(0, 2) * 16 + $urandom_range(0, 3));
      int d = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(1, 6));
      txn(1'($urandom_range(0, 1)), a, 8'($urandom), d, 8'($urandom));
    end

    // Saturation of hit_count.
    txn(0, 8'h1A, 8'h00, 1, 8'h5A);
    for (int n = 0; n < 300; n++) txn(0, 8'h1A, 8'h00, 1, 8'h00);
    check("hit_sat", hit_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
